layer_sequencer: RTL

Sequences one fully-connected layer pass over the 20-lane weight/bias RAM bank and the shared input/output activation RAM.
- Streams N input activations and the matching weights from all 20 weight RAMs in lockstep.
- Accumulates 20 dot products in parallel and adds each lane's bias.
- Writes 20 Q8.8 results back to the activation RAM.
- Driven by the top-level network controller: one Start per layer.

---
 rtl/nn_pkg.sv | 41 ++++
 rtl/mac_lane.sv | 58 +++++
 rtl/layer_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// nn_pkg: shared widths, types, sequencer states and Q8.8 saturation for the layer engine.
package nn_pkg;

  localparam int NEURONS   = 20;
  localparam int ADDR_W    = 10;
  localparam int WORD_W    = 16;
  localparam int ACC_W     = 40;
  localparam int RD_LAT    = 2;
  localparam int FRAC_BITS = 8;

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BIAS  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam acc_t SAT_HI = acc_t'((2 ** (WORD_W - 1)) - 1);
  localparam acc_t SAT_LO = acc_t'(-(2 ** (WORD_W - 1)));

  // Clamp an already-rescaled accumulator value into the signed word range.
  function automatic word_t sat_word(input acc_t a);
    word_t r;
    if (a > SAT_HI) begin
      r = word_t'(SAT_HI);
    end else if (a < SAT_LO) begin
      r = word_t'(SAT_LO);
    end else begin
      r = word_t'(a);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// mac_lane: one Q24.16 accumulator with Q8.8 rescale and saturation.
// Optional ReLU on the output when LAYER_SEQ_RELU_EN is defined.
module mac_lane
  import nn_pkg::*;
(
  input  logic  Clk,
  input  logic  Reset_n,
  input  logic  clear,
  input  logic  mac_en,
  input  logic  bias_en,
  input  word_t w,
  input  word_t x,
  output word_t result
);

  acc_t                acc_q;
  acc_t                acc_d;
  logic signed [31:0]  w_ext;
  logic signed [31:0]  x_ext;
  logic signed [31:0]  prod;
  acc_t                shifted;
  word_t               sat;

  always_comb begin
    w_ext = 32'(w);
    x_ext = 32'(x);
    prod  = w_ext * x_ext;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + acc_t'(prod);
    end else if (bias_en) begin
      // Bias is Q8.8; align it to the Q24.16 accumulator.
      acc_d = acc_q + (acc_t'(w) <<< FRAC_BITS);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign shifted = acc_q >>> FRAC_BITS;
  assign sat     = sat_word(shifted);

`ifdef LAYER_SEQ_RELU_EN
  assign result = sat[WORD_W-1] ? '0 : sat;
`else
  assign result = sat;
`endif

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// layer_sequencer: one fully-connected layer pass over NEURONS weight RAMs and the activation RAM.
// Optional ReLU output stage selected by LAYER_SEQ_RELU_EN (implemented in mac_lane).
module layer_sequencer
  import nn_pkg::*;
(
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             Start,
  input  logic [ADDR_W-1:0]                Num_Inputs,
  input  logic [ADDR_W-1:0]                In_Base,
  input  logic [ADDR_W-1:0]                Out_Base,
  output logic [NEURONS-1:0][ADDR_W-1:0]   W_Address,
  input  logic [NEURONS-1:0][WORD_W-1:0]   W_Q,
  output logic [ADDR_W-1:0]                IO_Address,
  output logic [WORD_W-1:0]                IO_D,
  output logic                             IO_Wren,
  input  logic [WORD_W-1:0]                IO_Q,
  output logic                             Busy,
  output logic                             Done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   in_base_q, in_base_d;
  logic [ADDR_W-1:0]   out_base_q, out_base_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [RD_LAT-1:0]   tag_v_q, tag_b_q;
  logic                push_v, push_b;
  logic                clear;
  logic                mac_en, bias_en;
  logic [ADDR_W-1:0]   w_addr;
  word_t               wr_word;
  word_t               result [NEURONS];

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    cnt_d      = cnt_q;
    push_v     = 1'b0;
    push_b     = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          n_d        = Num_Inputs;
          in_base_d  = In_Base;
          out_base_d = Out_Base;
          cnt_d      = '0;
          clear      = 1'b1;
          state_d    = (Num_Inputs == '0) ? BIAS : FETCH;
        end
      end
      FETCH: begin
        push_v = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) begin
          cnt_d   = '0;
          state_d = BIAS;
        end
      end
      BIAS: begin
        push_v  = 1'b1;
        push_b  = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_v_q == '0) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NEURONS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      cnt_q      <= '0;
      tag_v_q    <= '0;
      tag_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      cnt_q      <= cnt_d;
      tag_v_q    <= {tag_v_q[RD_LAT-2:0], push_v};
      tag_b_q    <= {tag_b_q[RD_LAT-2:0], push_b};
    end
  end

  // The tag leaving the pipe lines up with the RAM data for that issue slot.
  assign mac_en  = tag_v_q[RD_LAT-1] & ~tag_b_q[RD_LAT-1];
  assign bias_en = tag_v_q[RD_LAT-1] &  tag_b_q[RD_LAT-1];

  for (genvar k = 0; k < NEURONS; k++) begin : g_lane
    mac_lane u_lane (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .clear   (clear),
      .mac_en  (mac_en),
      .bias_en (bias_en),
      .w       (W_Q[k]),
      .x       (IO_Q),
      .result  (result[k])
    );
  end

  always_comb begin
    w_addr = '0;
    if (state_q == FETCH) begin
      w_addr = cnt_q;
    end else if (state_q == BIAS) begin
      w_addr = n_q;
    end
    IO_Address = '0;
    if (state_q == FETCH) begin
      IO_Address = in_base_q + cnt_q;
    end else if (state_q == WRITE) begin
      IO_Address = out_base_q + cnt_q;
    end
    wr_word = '0;
    for (int k = 0; k < NEURONS; k++) begin
      if (cnt_q == ADDR_W'(k)) begin
        wr_word = result[k];
      end
    end
  end

  assign W_Address = {NEURONS{w_addr}};
  assign IO_Wren   = (state_q == WRITE);
  assign IO_D      = (state_q == WRITE) ? wr_word : '0;
  assign Busy      = (state_q != IDLE) && (state_q != DONE);
  assign Done      = (state_q == DONE);

endmodule
`default_nettype wire
